// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - bus bundle between the fetch stage, decode/pipeline control and the instruction SRAM
//
// Signals:
//   stall           [5:0]  pipeline stall vector, stall[0] holds the PC
//   br_bus          [32:0] {br_e, br_addr} redirect from decode
//   if_to_id_bus    [32:0] {ce, pc} towards decode
//   inst_sram_en           SRAM read enable
//   inst_sram_wen   [3:0]  SRAM byte write enables (always zero)
//   inst_sram_addr  [31:0] SRAM fetch address
//   inst_sram_wdata [31:0] SRAM write data (always zero)
//   if_addr_err            fetch address misaligned while valid
// Modports: master = fetch stage, slave = its surroundings.
interface if_fetch_if;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        if_addr_err;

  modport master (
    input  stall, br_bus,
    output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
           inst_sram_wdata, if_addr_err
  );

  modport slave (
    output stall, br_bus,
    input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
           inst_sram_wdata, if_addr_err
  );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: owns the PC and drives the instruction SRAM port
//
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  if_fetch_if.master (stall, br_bus in; if_to_id_bus, inst_sram_*, if_addr_err out)
// Parameters:
//   RESET_PC  first fetched address after reset
//   PC_STEP   sequential PC increment
// Configuration:
//   IF_BR_HOLD_EN  when defined, a redirect arriving during stall[0] is remembered and
//                  applied on the first unstalled edge; otherwise it is dropped.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic         clk,
  input logic         rst,
  if_fetch_if.master  bus
);

  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] next_pc;
  logic        hold_pc;

  assign br_e    = bus.br_bus[32];
  assign br_addr = bus.br_bus[31:0];
  assign hold_pc = bus.stall[0];

  // Only stall[0] concerns this stage; the other bits belong to later stages.
  logic unused_stall_hi;
  assign unused_stall_hi = ^bus.stall[5:1];

`ifdef IF_BR_HOLD_EN
  logic        pend_v;
  logic [31:0] pend_addr;

  // A redirect seen while held is parked here; a later one overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v    <= 1'b0;
      pend_addr <= 32'b0;
    end else if (hold_pc) begin
      if (br_e) begin
        pend_v    <= 1'b1;
        pend_addr <= br_addr;
      end
    end else begin
      pend_v <= 1'b0;
    end
  end

  // A live redirect takes priority over the parked one.
  always_comb begin
    next_pc = pc_reg + PC_STEP;
    if (br_e) begin
      next_pc = br_addr;
    end else if (pend_v) begin
      next_pc = pend_addr;
    end
  end
`else
  always_comb begin
    next_pc = br_e ? br_addr : pc_reg + PC_STEP;
  end
`endif

  // Reset leaves pc one step before RESET_PC so the first increment lands on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC - PC_STEP;
      ce_reg <= 1'b0;
    end else if (!hold_pc) begin
      pc_reg <= next_pc;
      ce_reg <= 1'b1;
    end
  end

  assign bus.inst_sram_en    = ce_reg;
  assign bus.inst_sram_wen   = 4'b0;
  assign bus.inst_sram_addr  = pc_reg;
  assign bus.inst_sram_wdata = 32'b0;
  assign bus.if_to_id_bus    = {ce_reg, ce_reg ? pc_reg : 32'b0};
  assign bus.if_addr_err     = ce_reg && (pc_reg[1:0] != 2'b00);

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch
module tb_if_fetch;

`ifdef IF_BR_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk;
  logic rst;
  if_fetch_if ifc ();

  if_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: what address the stage should be presenting.
  bit          m_valid;
  bit          m_ce;
  logic [31:0] m_pc;
  bit          m_pend_v;
  logic [31:0] m_pend_addr;

  initial begin
    m_valid = 0;
    m_ce = 0;
    m_pc = 32'b0;
    m_pend_v = 0;
    m_pend_addr = 32'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1;
      m_ce     = 0;
      m_pc     = 32'hBFC0_0000 - 32'd4;
      m_pend_v = 0;
    end else if (!ifc.stall[0]) begin
      m_ce = 1;
      if (ifc.br_bus[32])
        m_pc = ifc.br_bus[31:0];
      else if (HOLD && m_pend_v)
        m_pc = m_pend_addr;
      else
        m_pc = m_pc + 32'd4;
      m_pend_v = 0;
    end else if (HOLD && ifc.br_bus[32]) begin
      m_pend_v    = 1;
      m_pend_addr = ifc.br_bus[31:0];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("m_en",   {32'b0, ifc.inst_sram_en}, {32'b0, m_ce});
      check("m_addr", {1'b0, ifc.inst_sram_addr}, {1'b0, m_pc});
      check("m_bus",  ifc.if_to_id_bus, {m_ce, m_ce ? m_pc : 32'b0});
      check("m_err",  {32'b0, ifc.if_addr_err}, {32'b0, m_ce && (m_pc[1:0] != 2'b00)});
      check("m_wen",  {29'b0, ifc.inst_sram_wen}, 33'b0);
      check("m_wdata", {1'b0, ifc.inst_sram_wdata}, 33'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] addr, input logic en, input logic err);
    check({name, "_addr"}, {1'b0, ifc.inst_sram_addr}, {1'b0, addr});
    check({name, "_en"},   {32'b0, ifc.inst_sram_en}, {32'b0, en});
    check({name, "_bus"},  ifc.if_to_id_bus, {en, en ? addr : 32'b0});
    check({name, "_err"},  {32'b0, ifc.if_addr_err}, {32'b0, err});
  endtask

  function automatic logic [31:0] rand_target();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return $urandom();
    if (k == 1) return 32'hFFFF_FFFC;
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    ifc.stall  = 6'b0;
    ifc.br_bus = 33'b0;

    // Reset masks everything regardless of other inputs.
    for (int i = 0; i < 3; i++) begin
      ifc.stall  = 6'($urandom());
      ifc.br_bus = {1'($urandom()), 32'($urandom())};
      tick();
      check("rst_en",  {32'b0, ifc.inst_sram_en}, 33'b0);
      check("rst_bus", ifc.if_to_id_bus, 33'b0);
      check("rst_err", {32'b0, ifc.if_addr_err}, 33'b0);
    end

    rst = 1'b0;
    ifc.stall  = 6'b0;
    ifc.br_bus = 33'b0;
    tick(); lit("seq0", 32'hBFC0_0000, 1'b1, 1'b0);
    tick(); lit("seq1", 32'hBFC0_0004, 1'b1, 1'b0);
    tick(); lit("seq2", 32'hBFC0_0008, 1'b1, 1'b0);

    ifc.br_bus = {1'b1, 32'hBFC0_0100};
    tick(); lit("br0", 32'hBFC0_0100, 1'b1, 1'b0);
    ifc.br_bus = 33'b0;
    tick(); lit("br1", 32'hBFC0_0104, 1'b1, 1'b0);

    ifc.br_bus = {1'b1, 32'hBFC0_000C};
    tick();
    ifc.br_bus = 33'b0;
    tick(); lit("pre_stall", 32'hBFC0_0010, 1'b1, 1'b0);

    ifc.stall = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      tick(); lit("stall", 32'hBFC0_0010, 1'b1, 1'b0);
    end
    ifc.stall = 6'b0;
    tick(); lit("unstall", 32'hBFC0_0014, 1'b1, 1'b0);

    // Redirect pulsed in the middle of a stall.
    ifc.stall = 6'b000001;
    tick();
    ifc.br_bus = {1'b1, 32'hBFC0_0200};
    tick();
    ifc.br_bus = 33'b0;
    tick(); lit("pend_hold", 32'hBFC0_0014, 1'b1, 1'b0);
    ifc.stall = 6'b0;
    tick(); lit("pend_rel", HOLD ? 32'hBFC0_0200 : 32'hBFC0_0018, 1'b1, 1'b0);

    ifc.br_bus = {1'b1, 32'hBFC0_0102};
    tick(); lit("misalign", 32'hBFC0_0102, 1'b1, 1'b1);
    ifc.br_bus = {1'b1, 32'hFFFF_FFFC};
    tick(); lit("top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    ifc.br_bus = 33'b0;
    tick(); lit("wrap", 32'h0000_0000, 1'b1, 1'b0);

    // Reset beats stall and redirect in the same cycle.
    rst = 1'b1;
    ifc.stall  = 6'b000001;
    ifc.br_bus = {1'b1, 32'h1234_5678};
    tick(); lit("mid_rst", 32'hBFBF_FFFC, 1'b0, 1'b0);
    rst = 1'b0;
    ifc.stall  = 6'b0;
    ifc.br_bus = 33'b0;
    tick(); lit("post_rst", 32'hBFC0_0000, 1'b1, 1'b0);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      ifc.stall  = {5'($urandom()), ($urandom_range(0, 99) < 35)};
      ifc.br_bus = {($urandom_range(0, 99) < 25), rand_target()};
      tick();
    end

    rst = 1'b0;
    ifc.stall  = 6'b0;
    ifc.br_bus = 33'b0;
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
